// File: rtl/lane_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lane_mem_ctrl
// Purpose  : Byte-lane data memory for the MEM stage. NUM_LANES byte-wide
//            banks hold little-endian data; accesses of 1/2/4/8 bytes may
//            start at any byte address and complete in one bank cycle.
//            Responses return in order through a small response FIFO with
//            load sign/zero extension, an error flag and a double-word
//            init store.
// Ports    : Clk, Reset_n         clock, asynchronous active-low reset
//            req_valid/req_ready  request handshake
//            req_we, req_addr, req_size, req_unsigned, req_wdata
//                                 request attributes and store data
//            init_en, init_wdata2 init mode: second word at addr+NUM_LANES
//            rsp_valid/rsp_ready  response handshake
//            rsp_rdata, rsp_err   extended load data, illegal-request flag
// Revision : 1.0  initial release
// ============================================================================
module lane_mem_ctrl #(
    parameter int NUM_LANES   = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int RSP_DEPTH   = 4
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [8*NUM_LANES-1:0] req_wdata,
    input  logic                   init_en,
    input  logic [8*NUM_LANES-1:0] init_wdata2,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [8*NUM_LANES-1:0] rsp_rdata,
    output logic                   rsp_err
);

    localparam int c_data_w = 8 * NUM_LANES;
    localparam int c_lane_w = $clog2(NUM_LANES);
    localparam int c_row_w  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int c_cap    = NUM_LANES * DEPTH_WORDS;
    localparam int c_ptr_w  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int c_cnt_w  = $clog2(RSP_DEPTH + 1);

    // Next row with top-of-memory wrap back to row 0.
    function automatic logic [c_row_w-1:0] row_inc(input logic [c_row_w-1:0] row);
        if (row == c_row_w'(DEPTH_WORDS - 1))
            row_inc = '0;
        else
            row_inc = row + c_row_w'(1);
    endfunction

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] ptr);
        if (ptr == c_ptr_w'(RSP_DEPTH - 1))
            ptr_inc = '0;
        else
            ptr_inc = ptr + c_ptr_w'(1);
    endfunction

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0]  r_outstanding;
    logic                w_accept;
    logic [3:0]          w_nbytes;
    logic                w_err;
    logic [c_lane_w-1:0] w_lane0;
    logic [c_row_w-1:0]  w_row0;
    logic [c_row_w-1:0]  w_row1;
    logic [c_row_w-1:0]  w_row2;

    // Outstanding counts everything from accept to handoff (pipeline stage
    // plus FIFO), so the FIFO can never overflow and req_ready is purely
    // registered.
    assign req_ready = (r_outstanding < c_cnt_w'(RSP_DEPTH));
    assign w_accept  = req_valid && req_ready;
    assign w_nbytes  = 4'd1 << req_size;
    assign w_err     = (req_addr >= ADDR_W'(c_cap))
                    || (w_nbytes > 4'(NUM_LANES))
                    || (init_en && (!req_we || (req_size != 2'(c_lane_w))));
    assign w_lane0   = req_addr[c_lane_w-1:0];
    assign w_row0    = req_addr[c_lane_w +: c_row_w];
    assign w_row1    = row_inc(w_row0);
    assign w_row2    = row_inc(w_row1);

    // ------------------------------------------------------------------
    // Byte-lane banks. Byte k of an access lands in lane (lane0+k); lanes
    // below lane0 have wrapped into the next row. The init word starts at
    // the same lane one row further on, so it uses rows +1/+2.
    // ------------------------------------------------------------------
    logic [c_data_w-1:0] w_rd_bytes;

    generate
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            localparam logic [c_lane_w-1:0] c_lane = c_lane_w'(l);

            logic [7:0]          r_mem [DEPTH_WORDS];
            logic [7:0]          r_rd;
            logic [c_lane_w-1:0] w_k;
            logic                w_wrapped;
            logic [c_row_w-1:0]  w_row_a;
            logic [c_row_w-1:0]  w_row_b;
            logic                w_we_a;
            logic                w_we_b;

            assign w_k       = c_lane - w_lane0;
            assign w_wrapped = (c_lane < w_lane0);
            assign w_row_a   = w_wrapped ? w_row1 : w_row0;
            assign w_row_b   = w_wrapped ? w_row2 : w_row1;
            assign w_we_a    = w_accept && req_we && !w_err && (4'(w_k) < w_nbytes);
            assign w_we_b    = w_accept && init_en && !w_err;

            always_ff @(posedge Clk) begin
                if (w_we_a)
                    r_mem[w_row_a] <= req_wdata[8*w_k +: 8];
                if (w_we_b)
                    r_mem[w_row_b] <= init_wdata2[8*w_k +: 8];
                if (w_accept)
                    r_rd <= r_mem[w_row_a];
            end

            assign w_rd_bytes[8*l +: 8] = r_rd;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: attributes travelling alongside the bank read
    // ------------------------------------------------------------------
    logic                r_s1_valid;
    logic                r_s1_err;
    logic                r_s1_we;
    logic                r_s1_unsigned;
    logic [1:0]          r_s1_size;
    logic [c_lane_w-1:0] r_s1_lane0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_err      <= 1'b0;
            r_s1_we       <= 1'b0;
            r_s1_unsigned <= 1'b0;
            r_s1_size     <= '0;
            r_s1_lane0    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_err      <= w_err;
                r_s1_we       <= req_we;
                r_s1_unsigned <= req_unsigned;
                r_s1_size     <= req_size;
                r_s1_lane0    <= w_lane0;
            end
        end
    end

    // Rotate lanes back into byte order, then extend above the access size.
    logic [3:0]          w_s1_nbytes;
    logic [c_data_w-1:0] w_raw;
    logic [c_data_w-1:0] w_ext;
    logic [c_lane_w-1:0] w_src;
    logic                w_sign;

    assign w_s1_nbytes = 4'd1 << r_s1_size;

    always_comb begin
        w_raw  = '0;
        w_ext  = '0;
        w_src  = '0;
        w_sign = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_src = r_s1_lane0 + c_lane_w'(k);
            w_raw[8*k +: 8] = w_rd_bytes[8*w_src +: 8];
            if (4'(k) == (w_s1_nbytes - 4'd1))
                w_sign = w_rd_bytes[8*w_src + 7] & ~r_s1_unsigned;
        end
        for (int k = 0; k < NUM_LANES; k++)
            w_ext[8*k +: 8] = (4'(k) < w_s1_nbytes) ? w_raw[8*k +: 8] : {8{w_sign}};
        if (r_s1_err || r_s1_we)
            w_ext = '0;
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [c_data_w-1:0] r_fifo_data [RSP_DEPTH];
    logic                r_fifo_err  [RSP_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_fifo_cnt;
    logic                w_pop;

    assign rsp_valid = (r_fifo_cnt != '0);
    assign w_pop     = rsp_valid && rsp_ready;
    assign rsp_rdata = rsp_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign rsp_err   = rsp_valid && r_fifo_err[r_rd_ptr];

    always_ff @(posedge Clk) begin
        if (r_s1_valid) begin
            r_fifo_data[r_wr_ptr] <= w_ext;
            r_fifo_err[r_wr_ptr]  <= r_s1_err;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fifo_cnt    <= '0;
            r_outstanding <= '0;
        end else begin
            if (r_s1_valid)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({r_s1_valid, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_cnt_w'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_cnt_w'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            case ({w_accept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + c_cnt_w'(1);
                2'b01:   r_outstanding <= r_outstanding - c_cnt_w'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lane_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lane_mem_ctrl
// Purpose  : Self-checking bench for lane_mem_ctrl (4 lanes, 1024 rows,
//            4-entry response FIFO). A table of single requests with
//            hand-computed results plus hand-written multi-cycle sequences
//            for back-to-back hazard, backpressure and mid-flight reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_lane_mem_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        init_en;
    logic [31:0] init_wdata2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    lane_mem_ctrl #(
        .NUM_LANES   (4),
        .DEPTH_WORDS (1024),
        .ADDR_W      (32),
        .RSP_DEPTH   (4)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .init_en      (init_en),
        .init_wdata2  (init_wdata2),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic        init;
        logic [31:0] wdata;
        logic [31:0] wdata2;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int c_num_vec    = 25;
    localparam int c_wrap_start = 20;

    vec_t tbl [c_num_vec];
    vec_t tx_q [$];
    vec_t exp_q [$];
    int   errors  = 0;
    int   checks  = 0;
    int   acc_cnt = 0;
    int   t;

    function automatic vec_t mk(input logic we, input logic [31:0] addr,
                                input logic [1:0] size, input logic uns,
                                input logic init, input logic [31:0] wdata,
                                input logic [31:0] wdata2,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.init = init;
        v.wdata = wdata; v.wdata2 = wdata2; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: entered and left at a falling edge. Drives the head of
    // tx_q, compares a response that will be handed off at the coming
    // rising edge, and moves accepted requests into the expected queue.
    task automatic tick(input logic rdy);
        logic acc;
        vec_t v;
        rsp_ready = rdy;
        if (tx_q.size() > 0) begin
            v            = tx_q[0];
            req_valid    = 1'b1;
            req_we       = v.we;
            req_addr     = v.addr;
            req_size     = v.size;
            req_unsigned = v.uns;
            req_wdata    = v.wdata;
            init_en      = v.init;
            init_wdata2  = v.wdata2;
        end else begin
            req_valid = 1'b0;
            init_en   = 1'b0;
        end
        if (rsp_valid && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata %h with no request outstanding", rsp_rdata);
            end else begin
                v = exp_q.pop_front();
                check($sformatf("rsp_rdata@%h", v.addr), rsp_rdata, v.exp_rdata);
                check($sformatf("rsp_err@%h", v.addr), {31'b0, rsp_err}, {31'b0, v.exp_err});
            end
        end
        acc = req_valid && req_ready;
        @(posedge Clk);
        if (acc) begin
            exp_q.push_back(tx_q.pop_front());
            acc_cnt++;
        end
        @(negedge Clk);
    endtask

    task automatic drain(input int budget, output int ticks);
        ticks = 0;
        while ((tx_q.size() > 0 || exp_q.size() > 0) && ticks < budget) begin
            tick(1'b1);
            ticks++;
        end
        if (tx_q.size() > 0 || exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d requests and %0d responses pending after %0d cycles, required 0",
                     tx_q.size(), exp_q.size(), ticks);
            tx_q.delete();
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              we    addr       sz    uns   init  wdata         wdata2        expect        err
        tbl[0]  = mk(1'b1, 32'h001,  2'd2, 1'b0, 1'b0, 32'hA1B2C3D4, 32'h0,        32'h00000000, 1'b0);
        tbl[1]  = mk(1'b0, 32'h001,  2'd2, 1'b0, 1'b0, 32'h0,        32'h0,        32'hA1B2C3D4, 1'b0);
        tbl[2]  = mk(1'b0, 32'h001,  2'd0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFFFFD4, 1'b0);
        tbl[3]  = mk(1'b0, 32'h004,  2'd0, 1'b1, 1'b0, 32'h0,        32'h0,        32'h000000A1, 1'b0);
        tbl[4]  = mk(1'b0, 32'h003,  2'd1, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0000A1B2, 1'b0);
        tbl[5]  = mk(1'b0, 32'h002,  2'd1, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFFB2C3, 1'b0);
        tbl[6]  = mk(1'b1, 32'h000,  2'd0, 1'b0, 1'b0, 32'h9999995A, 32'h0,        32'h00000000, 1'b0);
        tbl[7]  = mk(1'b0, 32'h000,  2'd2, 1'b0, 1'b0, 32'h0,        32'h0,        32'hB2C3D45A, 1'b0);
        tbl[8]  = mk(1'b0, 32'h1000, 2'd2, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00000000, 1'b1);
        tbl[9]  = mk(1'b1, 32'h1000, 2'd2, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h00000000, 1'b1);
        tbl[10] = mk(1'b0, 32'h000,  2'd2, 1'b0, 1'b0, 32'h0,        32'h0,        32'hB2C3D45A, 1'b0);
        tbl[11] = mk(1'b0, 32'h000,  2'd3, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00000000, 1'b1);
        tbl[12] = mk(1'b1, 32'h010,  2'd2, 1'b0, 1'b1, 32'hDEADBEEF, 32'h01234567, 32'h00000000, 1'b0);
        tbl[13] = mk(1'b0, 32'h010,  2'd2, 1'b0, 1'b0, 32'h0,        32'h0,        32'hDEADBEEF, 1'b0);
        tbl[14] = mk(1'b0, 32'h014,  2'd2, 1'b0, 1'b0, 32'h0,        32'h0,        32'h01234567, 1'b0);
        tbl[15] = mk(1'b0, 32'h010,  2'd2, 1'b0, 1'b1, 32'h0,        32'h0,        32'h00000000, 1'b1);
        tbl[16] = mk(1'b1, 32'h018,  2'd1, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1);
        tbl[17] = mk(1'b1, 32'h031,  2'd2, 1'b0, 1'b1, 32'hAABBCCDD, 32'h11223344, 32'h00000000, 1'b0);
        tbl[18] = mk(1'b0, 32'h033,  2'd2, 1'b0, 1'b0, 32'h0,        32'h0,        32'h3344AABB, 1'b0);
        tbl[19] = mk(1'b0, 32'h035,  2'd2, 1'b0, 1'b0, 32'h0,        32'h0,        32'h11223344, 1'b0);
        tbl[20] = mk(1'b1, 32'hFFE,  2'd2, 1'b0, 1'b0, 32'h11223344, 32'h0,        32'h00000000, 1'b0);
        tbl[21] = mk(1'b0, 32'h000,  2'd1, 1'b1, 1'b0, 32'h0,        32'h0,        32'h00001122, 1'b0);
        tbl[22] = mk(1'b0, 32'hFFE,  2'd1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00003344, 1'b0);
        tbl[23] = mk(1'b0, 32'hFFE,  2'd2, 1'b0, 1'b0, 32'h0,        32'h0,        32'h11223344, 1'b0);
        tbl[24] = mk(1'b0, 32'h001,  2'd0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00000011, 1'b0);

        Reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = '0;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        init_en      = 1'b0;
        init_wdata2  = '0;
        rsp_ready    = 1'b0;

        repeat (3) @(negedge Clk);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("reset_req_ready", {31'b0, req_ready}, 32'd1);

        // Single requests: unaligned, errors, init mode.
        for (int i = 0; i < c_wrap_start; i++) begin
            tx_q.push_back(tbl[i]);
            drain(20, t);
        end

        // Store followed next cycle by a load of the same bytes, full rate.
        tx_q.push_back(mk(1'b1, 32'h020, 2'd2, 1'b0, 1'b0, 32'hCAFEF00D, 32'h0, 32'h0, 1'b0));
        tx_q.push_back(mk(1'b0, 32'h020, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0));
        tx_q.push_back(mk(1'b0, 32'h023, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h000000CA, 1'b0));
        drain(20, t);
        check("b2b_cycles", t, 32'd5);

        // Backpressure: six signed byte loads from the init word pair.
        acc_cnt = 0;
        tx_q.push_back(mk(1'b0, 32'h010, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFFFFEF, 1'b0));
        tx_q.push_back(mk(1'b0, 32'h011, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFFFFBE, 1'b0));
        tx_q.push_back(mk(1'b0, 32'h012, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFFFFAD, 1'b0));
        tx_q.push_back(mk(1'b0, 32'h013, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFFFFDE, 1'b0));
        tx_q.push_back(mk(1'b0, 32'h014, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h00000067, 1'b0));
        tx_q.push_back(mk(1'b0, 32'h015, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h00000045, 1'b0));
        tick(1'b0);
        check("bp_first_accept", acc_cnt, 32'd1);
        check("lat_valid_after_T", {31'b0, rsp_valid}, 32'd0);
        tick(1'b0);
        check("lat_valid_after_T1", {31'b0, rsp_valid}, 32'd1);
        tick(1'b0);
        tick(1'b0);
        check("bp_accepts", acc_cnt, 32'd4);
        check("bp_req_ready", {31'b0, req_ready}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            check("bp_hold_rdata", rsp_rdata, 32'hFFFFFFEF);
            check("bp_hold_ready", {30'b0, rsp_valid, req_ready}, 32'd2);
        end
        check("bp_accepts_held", acc_cnt, 32'd4);
        drain(30, t);
        check("bp_total_accepts", acc_cnt, 32'd6);

        // Reset with three responses queued.
        acc_cnt = 0;
        for (int i = 0; i < 3; i++)
            tx_q.push_back(mk(1'b0, 32'h001, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 32'hA1B2C3D4, 1'b0));
        repeat (4) tick(1'b0);
        check("rst_pending_accepts", acc_cnt, 32'd3);
        check("rst_pending_valid", {31'b0, rsp_valid}, 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        check("rst_async_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_async_rdata", rsp_rdata, 32'd0);
        tx_q.delete();
        exp_q.delete();
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("rst_release_ready", {31'b0, req_ready}, 32'd1);
        check("rst_release_valid", {31'b0, rsp_valid}, 32'd0);
        tx_q.push_back(mk(1'b0, 32'h001, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 32'hA1B2C3D4, 1'b0));
        drain(20, t);

        // Top-of-memory wrap.
        for (int i = c_wrap_start; i < c_num_vec; i++) begin
            tx_q.push_back(tbl[i]);
            drain(20, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
